// File: rtl/duty_cmd_sequencer.sv
// duty_cmd_sequencer
//   Front-end controller for the DPWM duty-command counter. Debounces the raw
//   up/down buttons, arbitrates them against a host target-duty request and
//   issues one-cycle inc_o/dec_o strobes to the counter (step STEP, limit DMAX).
//   The counter value comes back on duty_fb and closes the seek loop.
//
//   Optional feature: define DUTY_SOFTSTART_EN to ramp the counter to
//   SOFT_DUTY after reset (one strobe every REPEAT_RATE_CYC cycles).
//
// Ports
//   clkm       in   system clock
//   reset      in   asynchronous, active-high reset
//   btn_up     in   raw up button (asynchronous)
//   btn_dn     in   raw down button (asynchronous)
//   tgt_valid  in   host target request valid
//   tgt_duty   in   host target duty (0..DMAX, larger values clamp to DMAX)
//   tgt_ready  out  host request can be accepted (IDLE)
//   duty_fb    in   current counter value
//   inc_o      out  one-cycle increment strobe
//   dec_o      out  one-cycle decrement strobe
//   busy       out  seek / soft-start in progress
module duty_cmd_sequencer #(
  parameter int DEBOUNCE_CYC     = 50000,
  parameter int REPEAT_START_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int STEP             = 25,
  parameter int DMAX             = 1000,
  parameter int SOFT_DUTY        = 500
) (
  input  logic       clkm,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       tgt_valid,
  input  logic [9:0] tgt_duty,
  output logic       tgt_ready,
  input  logic [9:0] duty_fb,
  output logic       inc_o,
  output logic       dec_o,
  output logic       busy
);

  localparam int TMAX = (REPEAT_START_CYC > REPEAT_RATE_CYC) ? REPEAT_START_CYC : REPEAT_RATE_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [10:0]   STEP11  = 11'(STEP);
  localparam logic [10:0]   DMAX11  = 11'(DMAX);
  localparam logic [TW-1:0] START_T = TW'(REPEAT_START_CYC - 1);
  localparam logic [TW-1:0] RATE_T  = TW'(REPEAT_RATE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    MANUAL,
    SEEK,
    SETTLE
`ifdef DUTY_SOFTSTART_EN
    , SOFT
`endif
  } state_t;

  // ---------------- button synchronizer + debounce (bit0 = up, bit1 = dn)
  logic [1:0]         sync1, sync2, deb, deb_q;
  logic [1:0][DW-1:0] dcnt;

  always_ff @(posedge clkm or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      dcnt  <= '0;
    end else begin
      sync1 <= {btn_dn, btn_up};
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        // any sample equal to the accepted level restarts the count
        if (sync2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end

  // a rising edge counts only if the other button is not held
  logic up_req, dn_req;
  assign up_req = deb[0] & ~deb_q[0] & ~deb[1];
  assign dn_req = deb[1] & ~deb_q[1] & ~deb[0];

  // ---------------- FSM
  state_t        state, nxt;
  logic [9:0]    tgt, tgt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          dir, dir_n, rep, rep_n, inc_n, dec_n;

  // 11-bit compares so duty_fb+STEP and tgt+STEP cannot wrap
  logic [10:0] fb11, tgt11;
  logic        can_inc, can_dec, want_inc, want_dec, held, other;
  assign fb11     = {1'b0, duty_fb};
  assign tgt11    = {1'b0, tgt};
  assign can_inc  = fb11 < DMAX11;
  assign can_dec  = duty_fb != '0;
  assign want_inc = (fb11 + STEP11) <= tgt11;
  assign want_dec = fb11 >= (tgt11 + STEP11);
  assign held     = dir ? deb[0] : deb[1];
  assign other    = dir ? deb[1] : deb[0];

  always_comb begin
    nxt   = state;
    tgt_n = tgt;
    tmr_n = tmr;
    dir_n = dir;
    rep_n = rep;
    inc_n = 1'b0;
    dec_n = 1'b0;
    // a button edge wins in every state except MANUAL (aborts seek/soft)
    if (state != MANUAL && (up_req || dn_req)) begin
      nxt   = MANUAL;
      dir_n = up_req;
      inc_n = up_req & can_inc;
      dec_n = dn_req & can_dec;
      tmr_n = '0;
      rep_n = 1'b0;
    end else begin
      case (state)
        IDLE:
          if (tgt_valid && tgt_ready) begin
            nxt   = SEEK;
            tgt_n = (({1'b0, tgt_duty}) > DMAX11) ? DMAX11[9:0] : tgt_duty;
          end
        MANUAL:
          if (!held || other) nxt = IDLE;
          else if (tmr == (rep ? RATE_T : START_T)) begin
            inc_n = dir & can_inc;
            dec_n = ~dir & can_dec;
            tmr_n = '0;
            rep_n = 1'b1;
          end else tmr_n = tmr + 1'b1;
        SEEK: begin
          tmr_n = '0;
          if (want_inc && can_inc) begin
            inc_n = 1'b1;
            nxt   = SETTLE;
          end else if (want_dec && can_dec) begin
            dec_n = 1'b1;
            nxt   = SETTLE;
          end else nxt = IDLE;
        end
        // two cycles: strobe reaches the counter, then duty_fb is current
        SETTLE:
          if (tmr == TW'(1)) nxt = SEEK;
          else tmr_n = tmr + 1'b1;
`ifdef DUTY_SOFTSTART_EN
        SOFT:
          if (tmr != '0) tmr_n = tmr - 1'b1;
          else if (want_inc && can_inc) begin
            inc_n = 1'b1;
            tmr_n = RATE_T;
          end else if (want_dec && can_dec) begin
            dec_n = 1'b1;
            tmr_n = RATE_T;
          end else nxt = IDLE;
`endif
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkm or posedge reset) begin
    if (reset) begin
`ifdef DUTY_SOFTSTART_EN
      state <= SOFT;
`else
      state <= IDLE;
`endif
      // only meaningful for soft-start; otherwise overwritten on acceptance
      tgt       <= 10'(SOFT_DUTY);
      tmr       <= '0;
      dir       <= 1'b0;
      rep       <= 1'b0;
      inc_o     <= 1'b0;
      dec_o     <= 1'b0;
      busy      <= 1'b0;
      tgt_ready <= 1'b0;
    end else begin
      state     <= nxt;
      tgt       <= tgt_n;
      tmr       <= tmr_n;
      dir       <= dir_n;
      rep       <= rep_n;
      inc_o     <= inc_n;
      dec_o     <= dec_n;
      tgt_ready <= (nxt == IDLE);
`ifdef DUTY_SOFTSTART_EN
      busy      <= (nxt == SEEK) || (nxt == SETTLE) || (nxt == SOFT);
`else
      busy      <= (nxt == SEEK) || (nxt == SETTLE);
`endif
    end
  end

endmodule

// File: tb/tb_duty_cmd_sequencer.sv
module tb_duty_cmd_sequencer;
  logic       clkm = 1'b0, reset = 1'b1;
  logic       btn_up = 1'b0, btn_dn = 1'b0, tgt_valid = 1'b0;
  logic [9:0] tgt_duty = '0;
  logic [9:0] fb;
  logic       tgt_ready, inc_o, dec_o, busy;

  int vectors = 0, miscompares = 0;
  int cyc = 0, n_inc = 0, n_dec = 0, last_inc = -100, last_dec = -100;
  int inc_t[$];

  duty_cmd_sequencer #(.DEBOUNCE_CYC(4), .REPEAT_START_CYC(20), .REPEAT_RATE_CYC(8)) dut (
    .clkm(clkm), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .tgt_valid(tgt_valid), .tgt_duty(tgt_duty), .tgt_ready(tgt_ready),
    .duty_fb(fb), .inc_o(inc_o), .dec_o(dec_o), .busy(busy));

  always #5 clkm = ~clkm;

  // counter model: step 25, reset to 0
  always @(posedge clkm or posedge reset) begin
    if (reset) fb <= '0;
    else if (inc_o) fb <= fb + 10'd25;
    else if (dec_o) fb <= fb - 10'd25;
  end

  always @(posedge clkm) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // strobe rules checked on every strobe
  always @(negedge clkm) begin
    if (!reset && (inc_o || dec_o)) begin
      chk("inc_dec_excl", int'(inc_o && dec_o), 0);
      if (inc_o) begin
        chk("inc_at_max", int'(fb >= 10'd1000), 0);
        chk("inc_gap", int'((cyc - last_inc) >= 3), 1);
        last_inc = cyc; n_inc++; inc_t.push_back(cyc);
      end
      if (dec_o) begin
        chk("dec_at_zero", int'(fb == 10'd0), 0);
        chk("dec_gap", int'((cyc - last_dec) >= 3), 1);
        last_dec = cyc; n_dec++;
      end
    end
  end

  // strobes while one button is held h cycles: 0, 20, 28, 36 ...
  function automatic int manual_strobes(input int h);
    int n = 1;
    for (int s = 20; s <= h - 1; s += 8) n++;
    return n;
  endfunction

  // seek endpoint: the STEP multiple within STEP of the clamped target
  function automatic int seek_end(input int f0, input int t);
    int c = (t > 1000) ? 1000 : t;
    if (f0 < c) return f0 + 25 * ((c - f0) / 25);
    return f0 - 25 * ((f0 - c) / 25);
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clkm); k++; end
    chk(tag, int'(busy), 0);
  endtask

  task automatic hold(input bit up, input int h);
    int f0 = fb, i0 = n_inc, d0 = n_dec, n = manual_strobes(h);
    inc_t.delete();
    @(negedge clkm);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    for (int k = 0; k < h; k++) begin
      @(negedge clkm);
      if (k == 10) chk("rdy_in_manual", int'(tgt_ready), 0);
    end
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (12) @(negedge clkm);
    chk(up ? "hold_inc_cnt" : "hold_dec_cnt", up ? n_inc - i0 : n_dec - d0, n);
    chk("hold_fb", int'(fb), up ? f0 + 25 * n : f0 - 25 * n);
    if (up) for (int i = 1; i < inc_t.size(); i++)
      chk("repeat_gap", inc_t[i] - inc_t[i-1], (i == 1) ? 20 : 8);
    chk("rdy_after_release", int'(tgt_ready), 1);
  endtask

  task automatic seek(input int t);
    int f0 = fb, i0 = n_inc, d0 = n_dec, e = seek_end(fb, t);
    @(negedge clkm);
    tgt_valid = 1'b1; tgt_duty = 10'(t);
    @(negedge clkm);
    tgt_valid = 1'b0;
    chk("seek_busy", int'(busy), 1);
    wait_idle("seek_timeout", 2000);
    chk("seek_fb", int'(fb), e);
    chk("seek_inc_cnt", n_inc - i0, (e > f0) ? (e - f0) / 25 : 0);
    chk("seek_dec_cnt", n_dec - d0, (e < f0) ? (f0 - e) / 25 : 0);
    chk("seek_rdy", int'(tgt_ready), 1);
  endtask

  initial begin
    int f0, i0, d0, k;
    // ---- reset state
    repeat (3) @(negedge clkm);
    chk("rst_inc", int'(inc_o), 0);
    chk("rst_dec", int'(dec_o), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rdy", int'(tgt_ready), 0);
    reset = 1'b0;
    @(negedge clkm);
`ifdef DUTY_SOFTSTART_EN
    chk("soft_busy", int'(busy), 1);
    wait_idle("soft_timeout", 1000);
    chk("soft_fb", int'(fb), 500);
    chk("soft_incs", n_inc, 20);
`else
    chk("idle_rdy", int'(tgt_ready), 1);
    chk("idle_busy", int'(busy), 0);
`endif

    // ---- 1: glitch rejected, short hold gives one strobe
    f0 = fb; i0 = n_inc;
    @(negedge clkm); btn_up = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clkm);
    btn_up = 1'b0;
    repeat (15) @(negedge clkm);
    chk("glitch_incs", n_inc - i0, 0);
    chk("glitch_fb", int'(fb), f0);
    hold(1'b1, 10);

    // ---- 2: auto-repeat
    hold(1'b1, 60);
    hold(1'b1, $urandom_range(12, 70));
    hold(1'b0, $urandom_range(12, 40));

    // ---- 3/4: host seeks, incl. clamp and both limits
    seek(0);
    seek(610);
    seek(1023);
    seek(0);
    for (int i = 0; i < 3; i++) seek($urandom_range(0, 1023));

    // ---- 5: button aborts a seek
    seek(0);
    i0 = n_inc; d0 = n_dec;
    @(negedge clkm); tgt_valid = 1'b1; tgt_duty = 10'd1000;
    @(negedge clkm); tgt_valid = 1'b0;
    repeat ($urandom_range(5, 30)) @(negedge clkm);
    btn_dn = 1'b1;
    k = 0;
    while (n_dec == d0 && k < 50) begin @(negedge clkm); k++; end
    chk("abort_timeout", int'(n_dec == d0), 0);
    f0 = n_inc;
    repeat (10) @(negedge clkm);
    chk("abort_no_inc", n_inc - f0, 0);
    chk("abort_one_dec", n_dec - d0, 1);
    chk("abort_fb", int'(fb), 25 * (n_inc - i0) - 25);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rdy", int'(tgt_ready), 0);
    btn_dn = 1'b0;
    repeat (15) @(negedge clkm);
    chk("abort_rdy_rel", int'(tgt_ready), 1);

    // ---- 6: both buttons, then reset mid-seek
    i0 = n_inc; d0 = n_dec;
    @(negedge clkm); btn_up = 1'b1; btn_dn = 1'b1;
    repeat (40) @(negedge clkm);
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (12) @(negedge clkm);
    chk("both_strobes", (n_inc - i0) + (n_dec - d0), 0);
    chk("both_rdy", int'(tgt_ready), 1);

    seek(0);
    @(negedge clkm); tgt_valid = 1'b1; tgt_duty = 10'd1000;
    @(negedge clkm); tgt_valid = 1'b0;
    repeat ($urandom_range(0, 20)) @(negedge clkm);
    k = 0;
    while (!inc_o && k < 50) begin @(negedge clkm); k++; end
    chk("rst_mid_seen_inc", int'(inc_o), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_inc", int'(inc_o), 0);
    chk("rst_mid_dec", int'(dec_o), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_rdy", int'(tgt_ready), 0);
    @(negedge clkm); @(negedge clkm);
    reset = 1'b0;
    i0 = n_inc;
`ifdef DUTY_SOFTSTART_EN
    @(negedge clkm);
    wait_idle("soft2_timeout", 1000);
    chk("soft2_fb", int'(fb), 500);
    chk("soft2_incs", n_inc - i0, 20);
`else
    repeat (30) @(negedge clkm);
    chk("post_rst_fb", int'(fb), 0);
    chk("post_rst_incs", n_inc - i0, 0);
    chk("post_rst_rdy", int'(tgt_ready), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
